// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and block geometry for the memory responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, BEAT} mem_state_t;
  localparam int BURST_LEN   = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int OFF_W       = 3;
endpackage

// File: rtl/data_array.sv
// data_array: synchronous-write, combinational-read word storage, not reset.
module data_array #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/memory_responder.sv
// memory_responder: fixed-latency single-word and critical-word-first burst memory responder.
module memory_responder
  import mem_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [15:0]       rsp_rdata,
  output logic [2:0]        rsp_beat
);
  localparam int AW = ADDR_W - 1;
  mem_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic             wr_q, wr_d, burst_q, burst_d;
  logic [AW-1:0]    waddr_q, waddr_d, raddr;
  logic [15:0]      rdata;
  logic             rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic [2:0]       rsp_beat_q, rsp_beat_d;
  logic             accept, last, unused_addr_lsb;

  assign req_ready       = state_q == IDLE;
  assign accept          = req_valid && req_ready;
  assign unused_addr_lsb = req_addr[0];
  // Offset wraps within the aligned block, so the upper word bits never change mid-burst.
  assign raddr = {waddr_q[AW-1:OFF_W], waddr_q[OFF_W-1:0] + beat_q};
  assign last  = !burst_q || beat_q == OFF_W'(BURST_LEN - 1);

  // Writes commit on the accept edge; the ack beat then reads back the stored word as its echo.
  data_array #(.AW(AW), .DW(16)) u_array (
    .clk   (clk),
    .we    (accept && req_wr),
    .waddr (req_addr[ADDR_W-1:1]),
    .wdata (req_wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    wr_d        = wr_q;
    burst_d     = burst_q;
    waddr_d     = waddr_q;
    rsp_valid_d = 1'b0;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_beat_d  = rsp_beat_q;
    case (state_q)
      IDLE: if (accept) begin
        wr_d    = req_wr;
        burst_d = req_burst && !req_wr;
        waddr_d = req_addr[ADDR_W-1:1];
        cnt_d   = 4'(LATENCY - 1);
        beat_d  = '0;
        state_d = LATENCY == 1 ? BEAT : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? BEAT : WAIT;
      end
      BEAT: begin
        rsp_valid_d = 1'b1;
        rsp_wr_d    = wr_q;
        rsp_rdata_d = rdata;
        rsp_beat_d  = raddr[OFF_W-1:0];
        beat_d      = beat_q + 1'b1;
        state_d     = last ? IDLE : BEAT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      wr_q        <= 1'b0;
      burst_q     <= 1'b0;
      waddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_beat_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      wr_q        <= wr_d;
      burst_q     <= burst_d;
      waddr_q     <= waddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_beat_q  <= rsp_beat_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_beat  = rsp_beat_q;
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed requests checked against a transaction-level memory model.
module tb_memory_responder;
  localparam int L = 4;
  logic        clk = 0, rst_n = 0, req_valid = 0, req_wr = 0, req_burst = 0;
  logic [15:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_wr;
  logic [15:0] rsp_rdata;
  logic [2:0]  rsp_beat;
  int total = 0, bad = 0, cyc = 0, free_at = 0, acc_cnt = 0;
  int acc_e0[$];
  logic [15:0] mem [int];
  typedef struct {int t; logic wr; logic [2:0] beat; logic [15:0] data;} beat_t;
  beat_t expq[$];
  logic [15:0] last_data = 0;
  logic [2:0]  cap_b [8];
  logic [15:0] cap_d [8];
  logic [2:0]  eb1 [8] = '{3, 4, 5, 6, 7, 0, 1, 2};
  logic [15:0] ed1 [8] = '{16'hA3, 16'hA4, 16'hA5, 16'hA6, 16'hA7, 16'hA0, 16'hA1, 16'hA2};
  logic [2:0]  eb2 [8] = '{7, 0, 1, 2, 3, 4, 5, 6};
  logic [15:0] ed2 [8] = '{16'hFFFE, 16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF8, 16'hFFFA, 16'hFFFC};
  logic [15:0] rot [4] = '{16'h0010, 16'h0022, 16'h0032, 16'h0034};

  memory_responder #(.LATENCY(L), .BURST_LEN(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .rsp_beat(rsp_beat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: responder is free once the last beat's edge has passed; beats land at E0+L+k.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      free_at = cyc;
      last_data = 0;
    end
    chk("req_ready", req_ready, cyc >= free_at);
    if (expq.size() > 0 && expq[0].t == cyc) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_wr", rsp_wr, expq[0].wr);
      chk("rsp_beat", rsp_beat, expq[0].beat);
      chk("rsp_rdata", rsp_rdata, expq[0].data);
      last_data = expq[0].data;
      void'(expq.pop_front());
    end else begin
      chk("rsp_valid_idle", rsp_valid, 0);
      chk("rsp_rdata_hold", rsp_rdata, last_data);
    end
    if (rst_n && req_valid && cyc >= free_at) begin
      int e0, w, n, ww;
      e0 = cyc + 1;
      w = int'(req_addr[15:1]);
      n = (req_burst && !req_wr) ? 8 : 1;
      if (req_wr) mem[w] = req_wdata;
      for (int k = 0; k < n; k++) begin
        ww = (w & ~7) | ((w + k) & 7);
        expq.push_back('{e0 + L + k, req_wr, 3'(ww), mem[ww]});
      end
      free_at = e0 + L + n - 1;
      acc_cnt++;
      acc_e0.push_back(e0);
    end
  end

  task automatic req(input logic wr, input logic burst, input logic [15:0] a, input logic [15:0] d);
    int start, n;
    @(posedge clk); #1;
    req_wr = wr; req_burst = burst; req_addr = a; req_wdata = d; req_valid = 1;
    start = acc_cnt; n = 0;
    while (acc_cnt == start && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (acc_cnt == start) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_beat(output int waits, output int lows);
    waits = 0; lows = 0;
    while (waits < 50) begin
      @(negedge clk);
      waits++;
      if (!req_ready) lows++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) chk("beat_timeout", 0, 1);
  endtask

  task automatic collect();
    int w, l;
    wait_beat(w, l);
    cap_b[0] = rsp_beat; cap_d[0] = rsp_rdata;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      cap_b[k] = rsp_beat; cap_d[k] = rsp_rdata;
    end
  endtask

  initial begin
    int w, l, n;
    #12;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_beat", rsp_beat, 0);
    chk("rst_wr", rsp_wr, 0);
    #10 rst_n = 1;
    req(1, 0, 16'h0010, 16'hBEEF);
    for (int k = 0; k < 8; k++) req(1, 0, 16'h0030 + 16'(2 * k), 16'h00A0 + 16'(k));
    for (int k = 0; k < 8; k++) req(1, 0, 16'hFFF0 + 16'(2 * k), 16'hFFF0 + 16'(2 * k));
    req(1, 0, 16'h0000, 16'hDEAD);
    req(0, 0, 16'h0010, 16'h0000);
    wait_beat(w, l);
    chk("rd_latency", w, L + 1);
    chk("rd_ready_low", l, L);
    chk("rd_data", rsp_rdata, 16'hBEEF);
    chk("rd_wr", rsp_wr, 0);
    chk("rd_beat", rsp_beat, 0);
    req(1, 1, 16'h0022, 16'h1234);
    wait_beat(w, l);
    chk("wr_ack", rsp_wr, 1);
    chk("wr_echo", rsp_rdata, 16'h1234);
    chk("wr_beat", rsp_beat, 1);
    req(0, 0, 16'h0022, 16'h0000);
    wait_beat(w, l);
    chk("rd_after_wr", rsp_rdata, 16'h1234);
    req(0, 1, 16'h0036, 16'h0000);
    collect();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("burst36_beat%0d", k), cap_b[k], eb1[k]);
      chk($sformatf("burst36_data%0d", k), cap_d[k], ed1[k]);
    end
    req(0, 1, 16'hFFFE, 16'h0000);
    collect();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("burstfe_beat%0d", k), cap_b[k], eb2[k]);
      chk($sformatf("burstfe_data%0d", k), cap_d[k], ed2[k]);
    end
    req(0, 1, 16'h0030, 16'h0000);
    req_wr = 0; req_burst = 0; req_valid = 1; n = 0;
    w = acc_cnt;
    while (acc_cnt == w && n < 100) begin
      req_addr = rot[n % 4];
      @(negedge clk); #1;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 0;
    chk("held_accept_gap", acc_e0[acc_e0.size() - 1] - acc_e0[acc_e0.size() - 2], L + 8);
    repeat (L + 2) @(negedge clk);
    req(1, 0, 16'h0040, 16'h5A5A);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_rdata", rsp_rdata, 0);
    @(posedge clk); #2;
    rst_n = 1;
    repeat (8) @(negedge clk);
    req(0, 0, 16'h0040, 16'h0000);
    wait_beat(w, l);
    chk("rd_after_rst", rsp_rdata, 16'h5A5A);
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
